dmux1_4_frame: RTL and testbench

- Receive-side counterpart of the 4:1 select mux: takes one WIDTH-bit sample per transfer, tagged with a 2-bit lane select, and routes it into one of four registered output lanes.
- Collects one full frame, meaning all four lanes written. Then presents the frame with a valid/ready handshake and stalls the input until the frame is accepted.
- Sits between a time-multiplexed 2-bit channel and four parallel consumers.

---
 rtl/dmux1_4_frame.sv | 95 +++++++++
 tb/tb_dmux1_4_frame.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dmux1_4_frame.sv
// 1:4 frame demultiplexer: steers lane-tagged samples into four output registers,
// then holds the completed frame behind a valid/ready handshake.
module dmux1_4_frame #(
   parameter int WIDTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       s,
   input  logic             clr,
   output logic [WIDTH-1:0] o0,
   output logic [WIDTH-1:0] o1,
   output logic [WIDTH-1:0] o2,
   output logic [WIDTH-1:0] o3,
   output logic             frame_valid,
   input  logic             frame_ready,
   output logic             dup_err,
   output logic [CNT_W-1:0] frame_cnt
);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       mask_q, mask_d;
   logic [WIDTH-1:0] lane_q [4];
   logic [WIDTH-1:0] lane_d [4];
   logic             dup_err_q, dup_err_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      lane_d      = lane_q;
      dup_err_d   = 1'b0;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         COLLECT: begin
            // An abort wins over a sample arriving on the same edge; the sample is dropped.
            if (clr) begin
               mask_d = '0;
            end else if (in_valid) begin
               lane_d[s] = in_data;
               if (mask_q[s]) begin
                  dup_err_d = 1'b1;
               end else begin
                  mask_d = mask_q | (4'b0001 << s);
                  if (mask_d == 4'b1111) state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (frame_ready) begin
               frame_cnt_d = frame_cnt_q + 1'b1;
               mask_d      = '0;
               state_d     = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // NOTE: the four lane registers are plain flops, so they are reset along with the rest of the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= COLLECT;
         mask_q      <= '0;
         dup_err_q   <= 1'b0;
         frame_cnt_q <= '0;
         for (int i = 0; i < 4; i++) lane_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         dup_err_q   <= dup_err_d;
         frame_cnt_q <= frame_cnt_d;
         lane_q      <= lane_d;
      end
   end

   assign in_ready    = (state_q == COLLECT);
   assign frame_valid = (state_q == HOLD);
   assign dup_err     = dup_err_q;
   assign frame_cnt   = frame_cnt_q;
   assign o0          = lane_q[0];
   assign o1          = lane_q[1];
   assign o2          = lane_q[2];
   assign o3          = lane_q[3];

endmodule

// File: tb/tb_dmux1_4_frame.sv
// Directed bench for dmux1_4_frame: a table of per-cycle vectors plus hand-written
// sequences for asynchronous reset and frame-counter wrap.
module tb_dmux1_4_frame;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_data;
   logic [1:0] s;
   logic       clr;
   logic [1:0] o0, o1, o2, o3;
   logic       frame_valid;
   logic       frame_ready;
   logic       dup_err;
   logic [7:0] frame_cnt;

   int n_vec  = 0;
   int n_fail = 0;

   dmux1_4_frame #(.WIDTH(2), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .s           (s),
      .clr         (clr),
      .o0          (o0),
      .o1          (o1),
      .o2          (o2),
      .o3          (o3),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .dup_err     (dup_err),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       iv;
      logic [1:0] s;
      logic [1:0] d;
      logic       clr;
      logic       fr;
      logic [1:0] o0, o1, o2, o3;
      logic       fv, ir, dup;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic iv, input logic [1:0] vs, input logic [1:0] d,
                      input logic c, input logic fr,
                      input logic [1:0] e0, input logic [1:0] e1,
                      input logic [1:0] e2, input logic [1:0] e3,
                      input logic fv, input logic ir, input logic dup, input logic [7:0] cnt);
      vec_t v;
      v.iv = iv; v.s = vs; v.d = d; v.clr = c; v.fr = fr;
      v.o0 = e0; v.o1 = e1; v.o2 = e2; v.o3 = e3;
      v.fv = fv; v.ir = ir; v.dup = dup; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   // Observed bundle: {o0,o1,o2,o3,frame_valid,in_ready,dup_err,frame_cnt}
   function automatic logic [18:0] obs();
      return {o0, o1, o2, o3, frame_valid, in_ready, dup_err, frame_cnt};
   endfunction

   task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got o=%h fv=%b ir=%b dup=%b cnt=%0d, want o=%h fv=%b ir=%b dup=%b cnt=%0d",
                  name, act[18:11], act[10], act[9], act[8], act[7:0],
                  exp[18:11], exp[10], exp[9], exp[8], exp[7:0]);
      end
   endtask

   task automatic drive(input logic iv, input logic [1:0] vs, input logic [1:0] d,
                        input logic c, input logic fr);
      in_valid = iv; s = vs; in_data = d; clr = c; frame_ready = fr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete in-order frame (lane i gets i) followed by a one-cycle accept.
   task automatic do_frame();
      for (int l = 0; l < 4; l++) begin
         drive(1'b1, 2'(l), 2'(l), 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
      step();
      drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
   endtask

   initial begin
      //   iv s  d  clr fr | o0 o1 o2 o3 fv ir dup cnt
      // In-order frame, frame_ready low.
      add(1, 0, 0, 0, 0,   0, 0, 0, 0,  0, 1, 0, 0);
      add(1, 1, 1, 0, 0,   0, 1, 0, 0,  0, 1, 0, 0);
      add(1, 2, 2, 0, 0,   0, 1, 2, 0,  0, 1, 0, 0);
      add(1, 3, 3, 0, 0,   0, 1, 2, 3,  1, 0, 0, 0);
      // HOLD ignores in_valid, then releases on frame_ready.
      add(1, 0, 3, 0, 0,   0, 1, 2, 3,  1, 0, 0, 0);
      add(1, 0, 3, 0, 0,   0, 1, 2, 3,  1, 0, 0, 0);
      add(1, 0, 3, 0, 0,   0, 1, 2, 3,  1, 0, 0, 0);
      add(0, 0, 0, 0, 1,   0, 1, 2, 3,  0, 1, 0, 1);
      // Duplicate write to lane 0, then complete the frame.
      add(1, 0, 1, 0, 0,   1, 1, 2, 3,  0, 1, 0, 1);
      add(1, 0, 2, 0, 0,   2, 1, 2, 3,  0, 1, 1, 1);
      add(1, 1, 0, 0, 0,   2, 0, 2, 3,  0, 1, 0, 1);
      add(1, 2, 0, 0, 0,   2, 0, 0, 3,  0, 1, 0, 1);
      add(1, 3, 0, 0, 0,   2, 0, 0, 0,  1, 0, 0, 1);
      // clr in HOLD is ignored; release.
      add(1, 0, 3, 1, 0,   2, 0, 0, 0,  1, 0, 0, 1);
      add(0, 0, 0, 0, 1,   2, 0, 0, 0,  0, 1, 0, 2);
      // Partial frame aborted by clr with a colliding sample on lane 2.
      add(1, 0, 3, 0, 0,   3, 0, 0, 0,  0, 1, 0, 2);
      add(1, 1, 3, 0, 0,   3, 3, 0, 0,  0, 1, 0, 2);
      add(1, 2, 1, 1, 0,   3, 3, 0, 0,  0, 1, 0, 2);
      // Full frame needed again; lane 0 rewrite is not a duplicate; frame_ready in COLLECT ignored.
      add(1, 0, 0, 0, 0,   0, 3, 0, 0,  0, 1, 0, 2);
      add(1, 1, 1, 0, 1,   0, 1, 0, 0,  0, 1, 0, 2);
      add(1, 2, 2, 0, 0,   0, 1, 2, 0,  0, 1, 0, 2);
      add(1, 3, 3, 0, 0,   0, 1, 2, 3,  1, 0, 0, 2);
      add(0, 0, 0, 0, 1,   0, 1, 2, 3,  0, 1, 0, 3);
      // Out-of-order frame with frame_ready tied high, then back-to-back frame.
      add(1, 3, 3, 0, 1,   0, 1, 2, 3,  0, 1, 0, 3);
      add(1, 1, 1, 0, 1,   0, 1, 2, 3,  0, 1, 0, 3);
      add(1, 2, 2, 0, 1,   0, 1, 2, 3,  0, 1, 0, 3);
      add(1, 0, 0, 0, 1,   0, 1, 2, 3,  1, 0, 0, 3);
      add(1, 0, 3, 0, 1,   0, 1, 2, 3,  0, 1, 0, 4);
      add(1, 0, 1, 0, 1,   1, 1, 2, 3,  0, 1, 0, 4);
      add(1, 1, 2, 0, 1,   1, 2, 2, 3,  0, 1, 0, 4);
      add(1, 2, 3, 0, 1,   1, 2, 3, 3,  0, 1, 0, 4);
      add(1, 3, 0, 0, 1,   1, 2, 3, 0,  1, 0, 0, 4);
      add(0, 0, 0, 0, 1,   1, 2, 3, 0,  0, 1, 0, 5);

      rst_n = 1'b0;
      drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
      #2;
      check("reset", obs(), {8'h00, 1'b0, 1'b1, 1'b0, 8'd0});
      #10;
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].iv, vecs[i].s, vecs[i].d, vecs[i].clr, vecs[i].fr);
         step();
         check($sformatf("vec%0d", i), obs(),
               {vecs[i].o0, vecs[i].o1, vecs[i].o2, vecs[i].o3,
                vecs[i].fv, vecs[i].ir, vecs[i].dup, vecs[i].cnt});
      end

      // Async reset after two lanes of a frame, applied between clock edges.
      drive(1'b1, 2'd0, 2'd1, 1'b0, 1'b0);
      step();
      drive(1'b1, 2'd1, 2'd2, 1'b0, 1'b0);
      step();
      rst_n = 1'b0;
      #1;
      check("rst_mid_frame", obs(), {8'h00, 1'b0, 1'b1, 1'b0, 8'd0});
      drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b1;

      // After reset all four lanes are needed again.
      for (int l = 0; l < 3; l++) begin
         drive(1'b1, 2'(l), 2'd3, 1'b0, 1'b0);
         step();
      end
      check("post_rst_3_lanes", obs(), {8'hFC, 1'b0, 1'b1, 1'b0, 8'd0});
      drive(1'b1, 2'd3, 2'd3, 1'b0, 1'b0);
      step();
      check("post_rst_4_lanes", obs(), {8'hFF, 1'b1, 1'b0, 1'b0, 8'd0});

      // Async reset while holding a frame.
      rst_n = 1'b0;
      #1;
      check("rst_in_hold", obs(), {8'h00, 1'b0, 1'b1, 1'b0, 8'd0});
      drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b1;

      // Counter preload to 255, then wrap.
      for (int f = 0; f < 255; f++) do_frame();
      check("cnt_255", obs(), {8'h1B, 1'b0, 1'b1, 1'b0, 8'd255});
      do_frame();
      check("cnt_wrap", obs(), {8'h1B, 1'b0, 1'b1, 1'b0, 8'd0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
